// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 4:1 bit mux through its channels with a
// programmable dwell and captures one bit per channel into a snapshot.
module mux_scan_ctrl #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       continuous,
   input  logic       mux_in,
   output logic [1:0] sel,
   output logic       busy,
   output logic [3:0] sample,
   output logic       valid
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    shadow;
   logic [3:0]    cap;
   logic          last_ch;
   logic          win_end;

   assign last_ch = (sel == 2'd3);
   assign win_end = (cnt == '0);

   // shadow with the bit of the current channel replaced by mux_in
   always_comb begin
      cap      = shadow;
      cap[sel] = mux_in;
   end

   // frame sequencer: state, select lines and dwell counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sel   <= 2'd0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         unique case (1'b1)
            (state == S_SCAN): begin
               if (!win_end) begin
                  cnt <= cnt - CW'(1);
               end else if (!last_ch) begin
                  sel <= sel + 2'd1;
                  cnt <= RELOAD;
               end else begin
                  state <= S_DONE;
               end
            end
            (state == S_DONE): begin
               sel <= 2'd0;
               if (continuous) begin
                  state <= S_SCAN;
                  cnt   <= RELOAD;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               sel  <= 2'd0;
               busy <= 1'b0;
               if (start) begin
                  state <= S_SCAN;
                  cnt   <= RELOAD;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // capture at each window end; publish the snapshot entering DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= 4'd0;
         sample <= 4'd0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (state == S_SCAN && win_end) begin
            shadow <= cap;
            if (last_ch) begin
               sample <= cap;
               valid  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: three instances (DWELL 4, 2, 1) scanned against a
// bench mux model; expected snapshots are queued and matched on valid.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start [3];
   logic       continuous [3];
   logic       mux_in [3];
   logic [1:0] sel [3];
   logic       busy [3];
   logic [3:0] sample [3];
   logic       valid [3];

   logic [3:0] data [3];
   logic       settle [3];
   int         tfirst [3];
   int         cyc = 0;

   int total = 0;
   int bad = 0;

   typedef struct {
      int         id;
      logic [3:0] d;
      int         at;
   } exp_t;

   exp_t q[$];

   function automatic int dw(input int g);
      return (g == 0) ? 4 : (g == 1) ? 2 : 1;
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 1;
      assign mux_in[g] = data[g][sel[g]] ^
         (settle[g] && (((cyc - tfirst[g]) % D) != D - 1));
      mux_scan_ctrl #(.DWELL(D)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[g]),
         .continuous (continuous[g]),
         .mux_in     (mux_in[g]),
         .sel        (sel[g]),
         .busy       (busy[g]),
         .sample     (sample[g]),
         .valid      (valid[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic launch(input int g, input logic [3:0] d,
                         input logic cont, output int t);
      @(negedge clk);
      data[g]       = d;
      continuous[g] = cont;
      start[g]      = 1'b1;
      t             = cyc + 1;
      tfirst[g]     = t;
      q.push_back('{g, d, t + 4 * dw(g)});
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   // scoreboard: every valid pulse must match the oldest expectation
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (valid[g]) begin
            if (q.size() == 0) begin
               chk("spurious_valid", {31'd0, valid[g]}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("valid_inst", g, e.id);
               chk("valid_cycle", cyc, e.at);
               chk("sample", {28'd0, sample[g]}, {28'd0, e.d});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t2;
      for (int g = 0; g < 3; g++) begin
         start[g]      = 1'b0;
         continuous[g] = 1'b0;
         data[g]       = 4'd0;
         settle[g]     = 1'b0;
         tfirst[g]     = 0;
      end

      // reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk("rst_sel", {30'd0, sel[g]}, 32'd0);
         chk("rst_busy", {31'd0, busy[g]}, 32'd0);
         chk("rst_valid", {31'd0, valid[g]}, 32'd0);
         chk("rst_sample", {28'd0, sample[g]}, 32'd0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single shot, DWELL=4
      launch(0, 4'b1010, 1'b0, t);
      for (int k = 0; k < 16; k++) begin
         wait_cyc(t + k);
         chk("ss_sel", {30'd0, sel[0]}, k / 4);
         chk("ss_busy", {31'd0, busy[0]}, 32'd1);
      end
      wait_cyc(t + 16);
      chk("ss_done_busy", {31'd0, busy[0]}, 32'd1);
      wait_cyc(t + 17);
      chk("ss_idle_busy", {31'd0, busy[0]}, 32'd0);
      chk("ss_idle_sel", {30'd0, sel[0]}, 32'd0);
      wait_cyc(t + 20);

      // settling: wrong data except the last cycle of each window
      settle[0] = 1'b1;
      launch(0, 4'b0110, 1'b0, t);
      wait_cyc(t + 18);
      settle[0] = 1'b0;
      chk("settle_hold", {28'd0, sample[0]}, 32'b0110);

      // reset mid-frame, DWELL=4
      launch(0, 4'b1111, 1'b0, t);
      wait_cyc(t + 8);
      void'(q.pop_back());
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_busy", {31'd0, busy[0]}, 32'd0);
      chk("mrst_valid", {31'd0, valid[0]}, 32'd0);
      chk("mrst_sample", {28'd0, sample[0]}, 32'd0);
      chk("mrst_sel", {30'd0, sel[0]}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("mrst_idle", {31'd0, busy[0]}, 32'd0);

      // continuous, DWELL=2
      launch(1, 4'b0011, 1'b1, t);
      wait_cyc(t + 8);
      data[1] = 4'b1100;
      q.push_back('{1, 4'b1100, t + 17});
      wait_cyc(t + 9);
      chk("cont_restart_sel", {30'd0, sel[1]}, 32'd0);
      chk("cont_busy", {31'd0, busy[1]}, 32'd1);
      wait_cyc(t + 12);
      continuous[1] = 1'b0;
      wait_cyc(t + 18);
      chk("cont_stop_busy", {31'd0, busy[1]}, 32'd0);
      wait_cyc(t + 24);
      chk("cont_stay_idle", {31'd0, busy[1]}, 32'd0);

      // DWELL=1 with start held through the frame
      @(negedge clk);
      data[2]  = 4'b1001;
      start[2] = 1'b1;
      t        = cyc + 1;
      q.push_back('{2, 4'b1001, t + 4});
      wait_cyc(t + 3);
      chk("held_busy", {31'd0, busy[2]}, 32'd1);
      wait_cyc(t + 4);
      start[2] = 1'b0;
      wait_cyc(t + 5);
      chk("held_idle", {31'd0, busy[2]}, 32'd0);
      wait_cyc(t + 6);
      chk("held_no_frame", {31'd0, busy[2]}, 32'd0);
      wait_cyc(t + 10);

      // back-to-back: start on the cycle busy falls
      launch(2, 4'b0110, 1'b0, t2);
      wait_cyc(t2 + 5);
      chk("b2b_fall", {31'd0, busy[2]}, 32'd0);
      data[2]  = 4'b1011;
      start[2] = 1'b1;
      q.push_back('{2, 4'b1011, t2 + 10});
      @(negedge clk);
      start[2] = 1'b0;
      chk("b2b_sel0", {30'd0, sel[2]}, 32'd0);
      chk("b2b_busy", {31'd0, busy[2]}, 32'd1);
      wait_cyc(t2 + 7);
      chk("b2b_sel1", {30'd0, sel[2]}, 32'd1);
      wait_cyc(t2 + 20);

      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer and capture stage wrapped around the 4:1 bit multiplexer. It drives the 2-bit select lines through channels 0..3, holding each for a programmable dwell time. It samples the multiplexer's single-bit output at the end of each dwell and presents the four captured bits as one snapshot with a one-cycle valid strobe. It runs single-shot or free-running.

## Interface
- DWELL, default 4: cycles each channel is held on `sel`; legal range 1..255.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin one scan frame; sampled only in IDLE.
- continuous  input  1  when high at frame end, immediately start the next frame.
- mux_in  input  1  multiplexer output bit being scanned.
- sel  output  2  select lines driven to the multiplexer.
- busy  output  1  high while a frame is in progress (SCAN or DONE).
- sample  output  4  last completed snapshot; `sample[k]` is `mux_in` captured while `sel == k`.
- valid  output  1  one-cycle pulse when `sample` updates.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **Internal registers:**
  - dwell counter `cnt`, width `max(1, clog2(DWELL))`;
  - 4-bit `shadow` capture register.
- **IDLE:**
  - `sel` = 0, `busy` = 0.
  - `start` = 1 → SCAN with `sel` = 0, `cnt` = DWELL-1.
- **SCAN:**
  - Each cycle with `cnt` != 0: `cnt` decrements and `sel` holds.
  - Cycle with `cnt` == 0:
    - `shadow[sel]` ← `mux_in`.
    - If `sel` < 3: `sel` increments and `cnt` reloads DWELL-1.
    - If `sel` == 3: go to DONE; `sel` holds 3.
- **DONE** (exactly one cycle):
  - `valid` = 1.
  - `sample` shows `shadow`, including the bit captured on the last SCAN cycle; register `sample` on entry to DONE.
  - Next state: `continuous` = 1 → SCAN with `sel` = 0, `cnt` = DWELL-1; otherwise → IDLE.
- **Input handling:**
  - `start` is ignored outside IDLE; no queuing.
  - `continuous` is examined only in DONE. Dropping it mid-frame lets the current frame finish, then the block returns to IDLE.
  - `start` and `continuous` together in IDLE → one frame starts; `continuous` decides at DONE.
- **Sample retention:**
  - `sample` holds its value between frames.
  - `shadow` bits not yet recaptured keep their previous-frame values; only `sample` is architecturally visible.
- **Reset:**
  - Values: `sel` = 0, `busy` = 0, `valid` = 0, `sample` = 0, `shadow` = 0, `cnt` = 0, state IDLE.
  - Reset mid-frame aborts the frame: no `valid`, `sample` = 0.
- DWELL = 1 is legal: one cycle per channel, capture every SCAN cycle.

## Timing
- `start` high in IDLE at edge T → `sel` = 0 and `busy` = 1 from T+1.
- Channel k is driven for cycles T+1+k·DWELL .. T+k·DWELL+DWELL.
- Capture happens on the last cycle of each channel's window. This gives `mux_in` DWELL-1 cycles of settling after each select change.
- `valid`/`sample` update: cycle T+1+4·DWELL. For DWELL=4 this is T+17; for DWELL=1, T+5.
- `busy` drops the cycle after DONE (single-shot). Frame occupancy is 4·DWELL+1 cycles.
- Continuous mode:
  - frame period 4·DWELL+1 cycles;
  - `valid` pulses exactly once per period and is never high on two consecutive cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` for 2 cycles at any state → all outputs 0 on the next edge. Apply `rst` at cycle 9 of a DWELL=4 frame → `busy` = 0, no `valid` pulse, `sample` = 0.
- **Single shot:** DWELL=4, multiplexer data 4'b1010, `start` pulse at T → `sel` reads 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; `valid` only at T+17 with `sample` = 4'b1010; `busy` = 0 at T+18.
- **Settling:** DWELL=4, `mux_in` glitched to the wrong value during the first 3 cycles of each channel window, correct on the 4th → `sample` equals the correct data 4'b0110.
- **Continuous:** DWELL=2, `continuous` = 1, data changes from 4'b0011 to 4'b1100 between frames → `valid` every 9 cycles; snapshots 4'b0011 then 4'b1100. Drop `continuous` mid-frame → that frame completes, then IDLE.
- **Ignored start / DWELL=1:**
  - DWELL=1: `start` held high through a frame → no second frame unless still high in IDLE.
  - DWELL=1, data 4'b1001 → `valid` at T+5 with `sample` = 4'b1001.
- **Back-to-back starts:** `start` re-asserted on the cycle `busy` falls → new frame begins; `sel` restarts at 0.
